ex_mem_wb_backend: RTL and testbench
====================================

Name: ex_mem_wb_backend

Overview:
Back half of the 8-bit teaching pipeline: it takes the EX-stage result, carries it through EX/MEM and MEM/WB registers, performs data-memory load/store, and drives the register-file write port (we/wa/wd). It is the writer end of the register file that the ID stage reads. It also produces the load indication consumed by the hazard unit, and the forwardA/forwardB selects plus forwarding data for the EX operand muxes.

Parameters:
DATA_W, 8, datapath width
REG_AW, 3, register address width (8 registers, r0 hardwired zero)
DMEM_AW, 4, data-memory address width (16 entries)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock; one clock domain, everything on rising edge
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  ID/EX holds a real instruction (0 = bubble/flush)
ex_op  in  4  opcode in EX
ex_rd  in  REG_AW  destination register in EX
ex_alu  in  DATA_W  ALU result in EX (memory address for LOAD/STORE)
ex_store_data  in  DATA_W  store data in EX (post-forwarding B operand)
id_ex_rs  in  REG_AW  rs of the instruction in EX, for forwarding
id_ex_rt  in  REG_AW  rt of the instruction in EX, for forwarding
id_ex_memread  out  1  comb: ex_valid && ex_op==OP_LOAD; to hazard unit
forwardA  out  2  select for operand A
forwardB  out  2  select for operand B
fwd_exmem_data  out  DATA_W  EX/MEM ALU result
fwd_memwb_data  out  DATA_W  MEM/WB write-back data
rf_we  out  1  register-file write enable
rf_wa  out  REG_AW  register-file write address
rf_wd  out  DATA_W  register-file write data
retired_cnt  out  CNT_W  count of valid instructions leaving WB

Behaviour:
- Opcodes: 0x0 NOP; 0x1-0x7 ALU ops that write rd; 0x8 LOAD (rd <= dmem[alu[DMEM_AW-1:0]]); 0x9 STORE (dmem[alu] <= store_data, no reg write); 0xA-0xF reserved, treated as NOP.
- regwrite = valid && (op in 0x1-0x8) && rd != 0. Writes to r0 are dropped everywhere.
- EX/MEM register: at the edge ending EX cycle n, latch {valid, op, rd, alu, store_data}.
- MEM cycle n+1:
  - dmem is read asynchronously at exmem.alu[DMEM_AW-1:0].
  - A STORE writes dmem at the edge ending n+1.
  - At that same edge, MEM/WB latches {valid, regwrite, rd, wb_data}, where wb_data = dmem read for LOAD and exmem.alu otherwise.
- WB cycle n+2: rf_we=memwb.regwrite, rf_wa=memwb.rd, rf_wd=memwb.wb_data. All three are driven straight from the MEM/WB register, with no combinational path from inputs. The register file commits at the edge ending n+2.
- Latency: EX to register-file commit is 2 edges after EX. A STORE followed by a LOAD to the same address reads the stored value (the store commits before the LOAD's MEM cycle).
- Forwarding (combinational), evaluated for X = rs→forwardA and rt→forwardB:
  - 2'b10 if exmem.regwrite && exmem.op != LOAD && exmem.rd == X.
  - Else 2'b01 if memwb.regwrite && memwb.rd == X.
  - Else 2'b00.
  - EX/MEM has priority. A LOAD in EX/MEM never forwards (the load-use stall upstream covers it).
- Distance-3 dependency (producer in WB while consumer in ID) is not forwarded here; the register file must be write-first.
- retired_cnt increments when memwb.valid is 1, including STOREs, and saturates at all-ones.
- Reset (at any time, including mid-flight): next edge clears all valid bits, the MEM/WB fields, dmem contents (all 0), and retired_cnt. After reset, rf_we=0, rf_wa=0, rf_wd=0, forwardA=forwardB=0, and fwd_* = 0. rst has priority over a same-edge STORE.
- A bubble (ex_valid=0) propagates as valid=0: no write, no forward, no count.

Decomposition:
- Package pipe_pkg: DATA_W/REG_AW/INSTR_W=20 constants, opcode constants OP_NOP/OP_LOAD/OP_STORE/OP_ALU_MIN/OP_ALU_MAX, forward codes FWD_NONE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10, and the instruction field positions (op[19:16], rs1[15:13], rs2[12:10], rd[9:7]).
- One sub-module: data_mem (sync write, async read, sync clear on rst).

Test Plan:
1. ALU op 0x1, rd=3, alu=0x2A, valid at cycle n -> in cycle n+2: rf_we=1, rf_wa=3, rf_wd=0x2A; retired_cnt=1 afterwards.
2. Op 0x2 rd=2 alu=0x10 at n, then a consumer with rs=2, rt=5 at n+1 -> forwardA=10, fwd_exmem_data=0x10, forwardB=00; the same consumer held at n+2 -> forwardA=01, fwd_memwb_data=0x10.
3. EX/MEM rd=4 alu=0x55 and MEM/WB rd=4 data=0x33, consumer rs=rt=4 -> forwardA=forwardB=10, data 0x55.
4. STORE alu=0x05 data=0xC3, then LOAD rd=1 alu=0x05 -> id_ex_memread=1 only in the LOAD EX cycle; no rf_we for the STORE; LOAD WB gives rf_we=1, rf_wa=1, rf_wd=0xC3. While the LOAD sits in EX/MEM, a consumer with rs=1 sees forwardA=00.
5. ALU op rd=0 alu=0x77, consumer rs=0 -> rf_we stays 0, forwardA=00; reserved op 0xC rd=3 -> no write, retired_cnt still increments.
6. Three instructions in flight, rst=1 for one cycle -> following cycle: rf_we=0, forwardA/B=00, retired_cnt=0; reading dmem[5] returns 0x00.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, opcodes, forwarding codes and pipeline-register layouts for the 8-bit teaching pipeline.
// No logic here; the helper functions are pure combinational decode used by the back end.
package pipe_pkg;

  localparam int DATA_W  = 8;
  localparam int REG_AW  = 3;
  localparam int DMEM_AW = 4;
  localparam int CNT_W   = 16;
  localparam int INSTR_W = 20;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] OP_NOP     = 4'h0;
  localparam logic [OP_W-1:0] OP_ALU_MIN = 4'h1;
  localparam logic [OP_W-1:0] OP_ALU_MAX = 4'h7;
  localparam logic [OP_W-1:0] OP_LOAD    = 4'h8;
  localparam logic [OP_W-1:0] OP_STORE   = 4'h9;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam int OP_MSB  = 19;
  localparam int OP_LSB  = 16;
  localparam int RS1_MSB = 15;
  localparam int RS1_LSB = 13;
  localparam int RS2_MSB = 12;
  localparam int RS2_LSB = 10;
  localparam int RD_MSB  = 9;
  localparam int RD_LSB  = 7;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store_data;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] wb_data;
  } memwb_t;

  // r0 is hardwired zero, so a write to it is never a real write (and never forwards).
  function automatic logic writes_reg(input logic valid, input logic [OP_W-1:0] op,
                                      input logic [REG_AW-1:0] rd);
    return valid && (op >= OP_ALU_MIN) && (op <= OP_LOAD) && (rd != '0);
  endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: synchronous write, asynchronous read, whole array cleared on rst.
// Latency: write lands at the clock edge, read is combinational; no backpressure.
// Reset wins over a same-edge write.
module data_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ex_mem_wb_backend.sv
// EX/MEM and MEM/WB registers, data memory access, register-file write port and EX operand forwarding.
// Latency: EX result commits to the register file 2 edges after its EX cycle; forwarding is combinational.
// No backpressure: one instruction (or bubble) enters per cycle, load-use stalls are handled upstream.
module ex_mem_wb_backend
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0] id_ex_rt,
  output logic              id_ex_memread,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic [DATA_W-1:0] fwd_exmem_data,
  output logic [DATA_W-1:0] fwd_memwb_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [CNT_W-1:0]  retired_cnt
);

  exmem_t              exmem, exmem_d;
  memwb_t              memwb, memwb_d;
  logic [DATA_W-1:0]   dmem_rdata;
  logic                dmem_we;

  assign dmem_we = exmem.valid && (exmem.op == OP_STORE);

  data_mem #(.AW(DMEM_AW), .DW(DATA_W)) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .we    (dmem_we),
    .waddr (exmem.alu[DMEM_AW-1:0]),
    .wdata (exmem.store_data),
    .raddr (exmem.alu[DMEM_AW-1:0]),
    .rdata (dmem_rdata)
  );

  always_comb begin
    exmem_d            = '0;
    exmem_d.valid      = ex_valid;
    exmem_d.regwrite   = writes_reg(ex_valid, ex_op, ex_rd);
    exmem_d.op         = ex_op;
    exmem_d.rd         = ex_rd;
    exmem_d.alu        = ex_alu;
    exmem_d.store_data = ex_store_data;

    memwb_d            = '0;
    memwb_d.valid      = exmem.valid;
    memwb_d.regwrite   = exmem.regwrite;
    memwb_d.rd         = exmem.rd;
    memwb_d.wb_data    = (exmem.op == OP_LOAD) ? dmem_rdata : exmem.alu;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem       <= '0;
      memwb       <= '0;
      retired_cnt <= '0;
    end else begin
      exmem <= exmem_d;
      memwb <= memwb_d;
      // Stores retire too; the counter sticks at all-ones rather than wrapping.
      if (memwb.valid && (retired_cnt != '1)) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // A load in EX/MEM has no data yet, so it never forwards; the hazard unit stalls the consumer instead.
  always_comb begin
    forwardA = FWD_NONE;
    forwardB = FWD_NONE;
    if (exmem.regwrite && (exmem.op != OP_LOAD) && (exmem.rd == id_ex_rs)) forwardA = FWD_EXMEM;
    else if (memwb.regwrite && (memwb.rd == id_ex_rs))                     forwardA = FWD_MEMWB;
    if (exmem.regwrite && (exmem.op != OP_LOAD) && (exmem.rd == id_ex_rt)) forwardB = FWD_EXMEM;
    else if (memwb.regwrite && (memwb.rd == id_ex_rt))                     forwardB = FWD_MEMWB;
  end

  assign id_ex_memread  = ex_valid && (ex_op == OP_LOAD);
  assign fwd_exmem_data = exmem.alu;
  assign fwd_memwb_data = memwb.wb_data;
  assign rf_we          = memwb.regwrite;
  assign rf_wa          = memwb.rd;
  assign rf_wd          = memwb.wb_data;

endmodule

// File: tb/tb_ex_mem_wb_backend.sv
// Directed plus randomized bench for ex_mem_wb_backend against an instruction-level reference model.
module tb_ex_mem_wb_backend;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic [3:0] ex_op;
  logic [2:0] ex_rd, id_ex_rs, id_ex_rt;
  logic [7:0] ex_alu, ex_store_data;
  logic       id_ex_memread;
  logic [1:0] forwardA, forwardB;
  logic [7:0] fwd_exmem_data, fwd_memwb_data;
  logic       rf_we;
  logic [2:0] rf_wa;
  logic [7:0] rf_wd;
  logic [15:0] retired_cnt;

  ex_mem_wb_backend dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_alu(ex_alu), .ex_store_data(ex_store_data), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .id_ex_memread(id_ex_memread), .forwardA(forwardA), .forwardB(forwardB),
    .fwd_exmem_data(fwd_exmem_data), .fwd_memwb_data(fwd_memwb_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic [2:0] rd;
    logic [7:0] alu;
    logic [7:0] sd;
  } ins_t;

  // Reference state: the instruction one cycle past EX, and the write-back it produced one cycle later.
  ins_t        m1;
  logic        m2_v, m2_rw;
  logic [2:0]  m2_rd;
  logic [7:0]  m2_d;
  logic [7:0]  mem [16];
  int unsigned cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic wr(input ins_t i);
    return i.v && (i.op >= 4'h1) && (i.op <= 4'h8) && (i.rd != 3'd0);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [2:0] src);
    if (wr(m1) && (m1.op != 4'h8) && (m1.rd == src)) return 2'b10;
    if (m2_rw && (m2_rd == src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_clear();
    m1 = '0; m2_v = 0; m2_rw = 0; m2_rd = 0; m2_d = 0; cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] op, input logic [2:0] rd,
                      input logic [7:0] alu, input logic [7:0] sd,
                      input logic [2:0] rs, input logic [2:0] rt);
    ins_t cur;
    @(negedge clk);
    rst = r; ex_valid = v; ex_op = op; ex_rd = rd; ex_alu = alu; ex_store_data = sd;
    id_ex_rs = rs; id_ex_rt = rt;
    #1;
    chk("memread",   id_ex_memread, v && (op == 4'h8));
    chk("forwardA",  forwardA, exp_fwd(rs));
    chk("forwardB",  forwardB, exp_fwd(rt));
    chk("fwd_exmem", fwd_exmem_data, m1.alu);
    chk("fwd_memwb", fwd_memwb_data, m2_d);
    chk("rf_we",     rf_we, m2_rw);
    chk("rf_wa",     rf_wa, m2_rd);
    chk("rf_wd",     rf_wd, m2_d);
    chk("retired",   retired_cnt, cnt);
    cur = '{v: v, op: op, rd: rd, alu: alu, sd: sd};
    if (r) begin
      model_clear();
    end else begin
      if (m2_v && cnt < 32'd65535) cnt++;
      m2_v  = m1.v;
      m2_rw = wr(m1);
      m2_rd = m1.rd;
      m2_d  = (m1.op == 4'h8) ? mem[m1.alu[3:0]] : m1.alu;
      if (m1.v && m1.op == 4'h9) mem[m1.alu[3:0]] = m1.sd;
      m1 = cur;
    end
  endtask

  task automatic bubble();
    step(0, 0, 4'h0, 3'd0, 8'h00, 8'h00, 3'd7, 3'd7);
  endtask

  initial begin
    rst = 1; ex_valid = 0; ex_op = 0; ex_rd = 0; ex_alu = 0; ex_store_data = 0;
    id_ex_rs = 0; id_ex_rt = 0;
    @(negedge clk);
    @(negedge clk);
    model_clear();

    // Reset state, then a single ALU write to r3
    step(0, 1, 4'h1, 3'd3, 8'h2A, 8'h00, 3'd7, 3'd7);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_fwdA", forwardA, 2'b00);
    bubble();
    bubble();
    chk("t1_we", rf_we, 1'b1);
    chk("t1_wa", rf_wa, 3'd3);
    chk("t1_wd", rf_wd, 8'h2A);
    bubble();
    chk("t1_cnt", retired_cnt, 16'd1);

    // EX/MEM then MEM/WB forwarding to a held consumer
    step(0, 1, 4'h2, 3'd2, 8'h10, 8'h00, 3'd7, 3'd7);
    step(0, 1, 4'h1, 3'd6, 8'h01, 8'h00, 3'd2, 3'd5);
    chk("t2_fa_exmem", forwardA, 2'b10);
    chk("t2_exmem_d", fwd_exmem_data, 8'h10);
    chk("t2_fb", forwardB, 2'b00);
    step(0, 1, 4'h1, 3'd6, 8'h01, 8'h00, 3'd2, 3'd5);
    chk("t2_fa_memwb", forwardA, 2'b01);
    chk("t2_memwb_d", fwd_memwb_data, 8'h10);

    // EX/MEM wins over MEM/WB for the same register
    step(0, 1, 4'h1, 3'd4, 8'h33, 8'h00, 3'd7, 3'd7);
    step(0, 1, 4'h3, 3'd4, 8'h55, 8'h00, 3'd7, 3'd7);
    step(0, 0, 4'h0, 3'd0, 8'h00, 8'h00, 3'd4, 3'd4);
    chk("t3_fa", forwardA, 2'b10);
    chk("t3_fb", forwardB, 2'b10);
    chk("t3_d", fwd_exmem_data, 8'h55);

    // Store then load of the same address; a load in EX/MEM does not forward
    step(0, 1, 4'h9, 3'd2, 8'h05, 8'hC3, 3'd7, 3'd7);
    chk("t4_mr_st", id_ex_memread, 1'b0);
    step(0, 1, 4'h8, 3'd1, 8'h05, 8'h00, 3'd7, 3'd7);
    chk("t4_mr_ld", id_ex_memread, 1'b1);
    step(0, 1, 4'h1, 3'd2, 8'h00, 8'h00, 3'd1, 3'd7);
    chk("t4_fa_load", forwardA, 2'b00);
    chk("t4_st_we", rf_we, 1'b0);
    bubble();
    chk("t4_ld_we", rf_we, 1'b1);
    chk("t4_ld_wa", rf_wa, 3'd1);
    chk("t4_ld_wd", rf_wd, 8'hC3);

    // r0 writes dropped; reserved opcode writes nothing but still retires
    step(0, 1, 4'h1, 3'd0, 8'h77, 8'h00, 3'd7, 3'd7);
    step(0, 1, 4'h0, 3'd0, 8'h00, 8'h00, 3'd0, 3'd7);
    chk("t5_fa_r0", forwardA, 2'b00);
    bubble();
    chk("t5_we_r0", rf_we, 1'b0);
    step(0, 1, 4'hC, 3'd3, 8'h12, 8'h00, 3'd7, 3'd7);
    bubble();
    bubble();
    chk("t5_we_rsv", rf_we, 1'b0);
    bubble();

    // Mid-flight reset clears pipeline, counter and memory
    step(0, 1, 4'h9, 3'd0, 8'h05, 8'h99, 3'd7, 3'd7);
    step(0, 1, 4'h1, 3'd3, 8'h21, 8'h00, 3'd7, 3'd7);
    step(0, 1, 4'h2, 3'd4, 8'h22, 8'h00, 3'd7, 3'd7);
    step(1, 1, 4'h1, 3'd5, 8'h23, 8'h00, 3'd3, 3'd4);
    step(0, 1, 4'h8, 3'd1, 8'h05, 8'h00, 3'd3, 3'd4);
    chk("t6_we", rf_we, 1'b0);
    chk("t6_fa", forwardA, 2'b00);
    chk("t6_fb", forwardB, 2'b00);
    chk("t6_cnt", retired_cnt, 16'd0);
    chk("t6_exmem_d", fwd_exmem_data, 8'h00);
    bubble();
    bubble();
    chk("t6_ld_we", rf_we, 1'b1);
    chk("t6_ld_wd", rf_wd, 8'h00);

    // Randomized traffic, biased toward memory ops over a small address space
    for (int n = 0; n < 3000; n++) begin
      logic       r, v;
      logic [3:0] op;
      int         sel;
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 3);
      op  = (sel == 0) ? 4'h8 : (sel == 1) ? 4'h9 : 4'($urandom_range(0, 15));
      step(r, v, op, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
